// File: rtl/onehot_enc_pkg.sv
// Shared types and helpers for the serial one-hot/bitmap index encoder.
// Optional zero-bitmap reporting is enabled with ONEHOT_ENC_ZERO_REPORT_EN.
package onehot_enc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2
    } state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lowest_set_idx(
        input logic [MAX_W-1:0] vec
    );
        int unsigned r;
        r = 0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) r = int'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: index of the lowest set bit of vec.
// Shared with onehot_encoder_serial (ONEHOT_ENC_ZERO_REPORT_EN build option).
module lowest_set_encoder
    import onehot_enc_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    localparam int CODE_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    assign any = |vec;
    assign idx = CODE_W'(lowest_set_idx(MAX_W'(vec)));

endmodule

// File: rtl/onehot_encoder_serial.sv
// Serialises a bitmap into the indices of its set bits, lowest first.
// Define ONEHOT_ENC_ZERO_REPORT_EN to emit one flagged beat for a zero bitmap.
module onehot_encoder_serial
    import onehot_enc_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    localparam int CODE_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last
`ifdef ONEHOT_ENC_ZERO_REPORT_EN
    ,
    output logic              out_zero
`endif
);

    state_e             state;
    logic [WIDTH-1:0]   pending;
    logic [WIDTH-1:0]   rest;
    logic [CODE_W-1:0]  low_idx;
    logic               any;
    logic               beat;
    logic               accept;
    state_e             empty_state;

    lowest_set_encoder #(.WIDTH(WIDTH)) u_enc (
        .vec (pending),
        .idx (low_idx),
        .any (any)
    );

    // pending with its lowest set bit removed
    assign rest = pending & (pending - WIDTH'(1));

`ifdef ONEHOT_ENC_ZERO_REPORT_EN
    assign out_zero    = (state == ZERO);
    assign out_valid   = any | out_zero;
    assign out_code    = out_zero ? '0 : low_idx;
    assign out_last    = out_zero | (any & (rest == '0));
    assign empty_state = ZERO;
`else
    assign out_valid   = any;
    assign out_code    = low_idx;
    assign out_last    = any & (rest == '0);
    assign empty_state = IDLE;
`endif

    assign beat     = out_valid & out_ready;
    assign in_ready = (state == IDLE) | (beat & out_last);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else if (accept) begin
            pending <= in_data;
            state   <= (in_data != '0) ? BUSY : empty_state;
        end else if (beat) begin
            pending <= rest;
            state   <= out_last ? IDLE : BUSY;
        end
    end

endmodule
